// File: rtl/ubc_multi_pkg.sv
// rtl/ubc_multi_pkg.sv - shared types, register layout and helpers for the user break controller
package ubc_multi_pkg;

   // Break bus-cycle condition, carried in the upper halfword of the +08 word
   typedef struct packed {
      logic [1:0] cd;   // 00 never, 01 CPU, 10 DMA, 11 either
      logic [1:0] id;   // 00 never, 01 ifetch, 10 data, 11 either
      logic [1:0] rw;   // 00 never, 01 read, 10 write, 11 either
      logic [1:0] sz;   // 00 any, else must equal the cycle size
   } bbr_t;

   // Break control fields, sized for the largest channel count
   typedef struct packed {
      logic [7:0] dbe;
      logic       seq;
      logic [7:0] cmf;
   } brcr_t;

   typedef enum logic {SEQ_IDLE = 1'b0, SEQ_ARMED = 1'b1} seq_state_t;

   localparam logic [31:0] REG_INIT = 32'h0000_0000;
   localparam logic [2:0]  OFS_BAR  = 3'd0;
   localparam logic [2:0]  OFS_BAMR = 3'd1;
   localparam logic [2:0]  OFS_BBR  = 3'd2;
   localparam logic [2:0]  OFS_BDR  = 3'd4;
   localparam logic [2:0]  OFS_BDMR = 3'd5;

   // Expand byte enables into a bit mask (BA[3] is the most significant byte)
   function automatic logic [31:0] lane_mask(input logic [3:0] ba);
      return {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [31:0] m);
      return (old & ~m) | (din & m);
   endfunction

   // BBR lives in bits [23:16] of the bus word; only that byte lane updates it
   function automatic bbr_t bbr_write(input bbr_t old, input logic [31:0] din, input logic [3:0] ba);
      return ba[2] ? bbr_t'(din[23:16]) : old;
   endfunction

   function automatic logic [31:0] bbr_read(input bbr_t b);
      return {8'h00, b, 16'h0000};
   endfunction

   function automatic logic [31:0] brcr_read(input brcr_t b);
      return {8'h00, b.dbe, b.seq, 7'h00, b.cmf};
   endfunction

endpackage

// File: rtl/ubc_multi_chan_match.sv
// rtl/ubc_multi_chan_match.sv - combinational match of one break channel against the monitored cycle
module ubc_chan_match
   import ubc_multi_pkg::*;
(
   input  logic [31:0] bar,
   input  logic [31:0] bamr,
   input  bbr_t        bbr,
   input  logic [31:0] bdr,
   input  logic [31:0] bdmr,
   input  logic        dbe,
   input  logic [31:0] mon_a,
   input  logic [31:0] mon_d,
   input  logic [1:0]  mon_sz,
   input  logic        mon_we,
   input  logic        mon_if,
   input  logic        mon_dma,
   input  logic        mon_valid,
   output logic        match
);

   logic cd_ok, id_ok, rw_ok, sz_ok, addr_ok, data_ok;

   // Each condition field is a two-bit enable set; size and data are skipped for fetches
   always_comb begin
      cd_ok   = mon_dma ? bbr.cd[1] : bbr.cd[0];
      id_ok   = mon_if  ? bbr.id[0] : bbr.id[1];
      rw_ok   = mon_we  ? bbr.rw[1] : bbr.rw[0];
      sz_ok   = (bbr.sz == 2'b00) || mon_if || (bbr.sz == mon_sz);
      addr_ok = ((mon_a ^ bar) & ~bamr) == 32'h0;
      data_ok = !dbe || mon_if || (((mon_d ^ bdr) & ~bdmr) == 32'h0);
      match   = mon_valid & cd_ok & id_ok & rw_ok & sz_ok & addr_ok & data_ok;
   end

endmodule

// File: rtl/ubc_multi.sv
// rtl/ubc_multi.sv - multi-channel user break controller with match pipeline and break IRQ
module ubc_multi
   import ubc_multi_pkg::*;
#(
   parameter int          NUM_CH = 2,
   parameter logic [31:0] BASE   = 32'hFFFF_FF40
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        RES_N,
   input  logic [31:0] IBUS_A,
   input  logic [31:0] IBUS_DI,
   output logic [31:0] IBUS_DO,
   input  logic [3:0]  IBUS_BA,
   input  logic        IBUS_WE,
   input  logic        IBUS_REQ,
   output logic        IBUS_BUSY,
   output logic        IBUS_ACT,
   input  logic [31:0] MON_A,
   input  logic [31:0] MON_D,
   input  logic [1:0]  MON_SZ,
   input  logic        MON_WE,
   input  logic        MON_IF,
   input  logic        MON_DMA,
   input  logic        MON_VALID,
   output logic        IRQ
);

   localparam logic [31:0] WIN = 32'(NUM_CH * 32 + 4);

   logic [31:0]       off, lm, rd_mux, reg_do;
   logic [26:0]       blk;
   logic [2:0]        word;
   logic              reg_sel, wr_en, brcr_hit, brcr_wr, seq, seq_nx;
   logic [31:0]       bar [NUM_CH];
   logic [31:0]       bamr [NUM_CH];
   logic [31:0]       bdr [NUM_CH];
   logic [31:0]       bdmr [NUM_CH];
   bbr_t              bbr [NUM_CH];
   logic [NUM_CH-1:0] cmf, dbe, dbe_nx, match_vec, match_q, set_vec, clr_vec, irq_src;
   seq_state_t        state, state_nx;
   brcr_t             br;

   assign off       = IBUS_A - BASE;
   assign blk       = off[31:5];
   assign word      = off[4:2];
   assign reg_sel   = IBUS_REQ && (off < WIN);
   assign brcr_hit  = reg_sel && (blk == 27'(NUM_CH)) && (word == 3'd0);
   assign wr_en     = reg_sel & IBUS_WE;
   assign brcr_wr   = wr_en & brcr_hit;
   assign lm        = lane_mask(IBUS_BA);
   assign IBUS_ACT  = reg_sel;
   assign IBUS_BUSY = 1'b0;
   assign IBUS_DO   = reg_sel ? reg_do : 32'h0;

   // Control-register next values and the write-0-to-clear mask for the flags
   always_comb begin
      seq_nx  = (brcr_wr && IBUS_BA[1]) ? IBUS_DI[15] : seq;
      dbe_nx  = (brcr_wr && IBUS_BA[2]) ? IBUS_DI[16 +: NUM_CH] : dbe;
      clr_vec = (brcr_wr && IBUS_BA[0]) ? ~IBUS_DI[NUM_CH-1:0] : '0;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_chan
         ubc_chan_match u_match (
            .bar(bar[g]), .bamr(bamr[g]), .bbr(bbr[g]), .bdr(bdr[g]), .bdmr(bdmr[g]),
            .dbe(dbe[g]), .mon_a(MON_A), .mon_d(MON_D), .mon_sz(MON_SZ), .mon_we(MON_WE),
            .mon_if(MON_IF), .mon_dma(MON_DMA), .mon_valid(MON_VALID), .match(match_vec[g])
         );
      end
   endgenerate

   // Per-channel condition registers, written with byte lanes on the rising phase
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int n = 0; n < NUM_CH; n++) begin
            bar[n] <= REG_INIT; bamr[n] <= REG_INIT; bdr[n] <= REG_INIT; bdmr[n] <= REG_INIT;
            bbr[n] <= '0;
         end
      end else if (CE_R) begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (!RES_N) begin
               bar[n] <= REG_INIT; bamr[n] <= REG_INIT; bdr[n] <= REG_INIT; bdmr[n] <= REG_INIT;
               bbr[n] <= '0;
            end else if (wr_en && blk == 27'(n)) begin
               case (word)
                  OFS_BAR:  bar[n]  <= merge(bar[n], IBUS_DI, lm);
                  OFS_BAMR: bamr[n] <= merge(bamr[n], IBUS_DI, lm);
                  OFS_BBR:  bbr[n]  <= bbr_write(bbr[n], IBUS_DI, IBUS_BA);
                  OFS_BDR:  bdr[n]  <= merge(bdr[n], IBUS_DI, lm);
                  OFS_BDMR: bdmr[n] <= merge(bdmr[n], IBUS_DI, lm);
                  default: ;
               endcase
            end
         end
      end
   end

   // Sequential-mode flag steering: channel 1 only counts once channel 0 has armed the FSM
   always_comb begin
      state_nx = state;
      set_vec  = match_q;
      if (seq) begin
         set_vec[1] = 1'b0;
         case (state)
            SEQ_IDLE: if (match_q[0]) state_nx = SEQ_ARMED;
            SEQ_ARMED: begin
               set_vec[1] = match_q[1];
               if (match_q[1] || (clr_vec[0] && !match_q[0])) state_nx = SEQ_IDLE;
            end
            default: state_nx = SEQ_IDLE;
         endcase
      end
      if (!seq_nx) state_nx = SEQ_IDLE;
   end

   // Sequence FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      state <= SEQ_IDLE;
      else if (CE_R)   state <= RES_N ? state_nx : SEQ_IDLE;
   end

   // In sequential mode a channel-0 flag alone is only a precondition, not a break
   always_comb begin
      irq_src = cmf;
      if (seq) irq_src[0] = 1'b0;
   end

   // Match pipeline: raw match, then flags (set beats clear), then registered IRQ
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         match_q <= '0; cmf <= '0; seq <= 1'b0; dbe <= '0; IRQ <= 1'b0;
      end else if (CE_R) begin
         if (!RES_N) begin
            match_q <= '0; cmf <= '0; seq <= 1'b0; dbe <= '0; IRQ <= 1'b0;
         end else begin
            match_q <= match_vec;
            cmf     <= (cmf & ~clr_vec) | set_vec;
            seq     <= seq_nx;
            dbe     <= dbe_nx;
            IRQ     <= |irq_src;
         end
      end
   end

   // Read multiplexer over the register window; unmapped offsets return 0
   always_comb begin
      br     = '0;
      br.cmf[NUM_CH-1:0] = cmf;
      br.dbe[NUM_CH-1:0] = dbe;
      br.seq = seq;
      rd_mux = 32'h0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (blk == 27'(n)) begin
            case (word)
               OFS_BAR:  rd_mux = bar[n];
               OFS_BAMR: rd_mux = bamr[n];
               OFS_BBR:  rd_mux = bbr_read(bbr[n]);
               OFS_BDR:  rd_mux = bdr[n];
               OFS_BDMR: rd_mux = bdmr[n];
               default:  rd_mux = 32'h0;
            endcase
         end
      end
      if (brcr_hit) rd_mux = brcr_read(br);
   end

   // Read data is captured on the falling phase
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)     reg_do <= 32'h0;
      else if (CE_F)  reg_do <= rd_mux;
   end

endmodule

// File: tb/tb_ubc_multi.sv
// tb/tb_ubc_multi.sv - scoreboard bench for the user break controller
module tb_ubc_multi;

   logic        clk = 1'b0, rst_n = 1'b0, ph = 1'b0, res_n = 1'b1;
   logic        ce_r, ce_f;
   logic [31:0] ibus_a = '0, ibus_di = '0;
   logic [3:0]  ibus_ba = 4'hF;
   logic        ibus_we = 1'b0, ibus_req = 1'b0;
   logic [31:0] mon_a = '0, mon_d = '0;
   logic [1:0]  mon_sz = 2'b11;
   logic        mon_we = 1'b0, mon_if = 1'b0, mon_dma = 1'b0, mon_valid = 1'b0;
   logic [31:0] do2, do4, rdat, rdat4;
   logic        busy2, busy4, act2, act4, irq2, irq4, ract;

   typedef struct { string tag; int due; logic exp; } sb_t;
   sb_t sb[$];
   int  checks = 0, errors = 0, r_cnt = 0;

   assign ce_r = ph;
   assign ce_f = ~ph;

   always #5 clk = ~clk;
   always @(negedge clk) ph <= ~ph;

   ubc_multi #(.NUM_CH(2)) u_dut (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n),
      .IBUS_A(ibus_a), .IBUS_DI(ibus_di), .IBUS_DO(do2), .IBUS_BA(ibus_ba), .IBUS_WE(ibus_we),
      .IBUS_REQ(ibus_req), .IBUS_BUSY(busy2), .IBUS_ACT(act2),
      .MON_A(mon_a), .MON_D(mon_d), .MON_SZ(mon_sz), .MON_WE(mon_we), .MON_IF(mon_if),
      .MON_DMA(mon_dma), .MON_VALID(mon_valid), .IRQ(irq2)
   );

   ubc_multi #(.NUM_CH(4)) u_dut4 (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n),
      .IBUS_A(ibus_a), .IBUS_DI(ibus_di), .IBUS_DO(do4), .IBUS_BA(ibus_ba), .IBUS_WE(ibus_we),
      .IBUS_REQ(ibus_req), .IBUS_BUSY(busy4), .IBUS_ACT(act4),
      .MON_A(mon_a), .MON_D(mon_d), .MON_SZ(mon_sz), .MON_WE(mon_we), .MON_IF(mon_if),
      .MON_DMA(mon_dma), .MON_VALID(mon_valid), .IRQ(irq4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock; on rising-phase edges, retire every scoreboard entry that has come due
   task automatic tick(output logic was_r);
      sb_t e;
      @(posedge clk);
      was_r = ce_r;
      #1;
      if (was_r) begin
         r_cnt++;
         while (sb.size() > 0 && sb[0].due <= r_cnt) begin
            e = sb.pop_front();
            chk(e.tag, {31'b0, irq2}, {31'b0, e.exp});
         end
      end
   endtask

   task automatic cycle_r();
      logic w;
      do tick(w); while (!w);
   endtask

   task automatic cycle_f();
      logic w;
      do tick(w); while (w);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ibus_a = a; ibus_di = d; ibus_we = 1'b1; ibus_req = 1'b1;
      cycle_r();
      ibus_we = 1'b0; ibus_req = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      ibus_a = a; ibus_we = 1'b0; ibus_req = 1'b1;
      cycle_f();
      rdat = do2; rdat4 = do4; ract = act2;
      ibus_req = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      rd(a);
      chk(tag, rdat, exp);
   endtask

   // One monitored cycle; IRQ is expected unchanged for two rising phases, then at its new level
   task automatic mon(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic we, input logic ifc, input logic dma,
                      input logic irq_before, input logic irq_after);
      mon_a = a; mon_d = d; mon_sz = sz; mon_we = we; mon_if = ifc; mon_dma = dma; mon_valid = 1'b1;
      cycle_r();
      mon_valid = 1'b0;
      sb.push_back('{tag: {tag, "_early"}, due: r_cnt + 1, exp: irq_before});
      sb.push_back('{tag: tag, due: r_cnt + 2, exp: irq_after});
      repeat (3) cycle_r();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) cycle_r();

      // Reset state
      chk("rst_irq", {31'b0, irq2}, 32'h0);
      chk("rst_busy", {31'b0, busy2}, 32'h0);
      rd_chk("rst_bar0", 32'hFFFF_FF40, 32'h0);
      rd_chk("rst_brcr", 32'hFFFF_FF80, 32'h0);

      // BRCR placement and masks for both channel counts
      wr(32'hFFFF_FFC0, 32'h00FF_80FF);
      rd(32'hFFFF_FFC0);
      chk("brcr4_rd", rdat4, 32'h000F_8000);
      chk("brcr4_dut2_do", rdat, 32'h0);
      chk("brcr4_dut2_act", {31'b0, ract}, 32'h0);
      wr(32'hFFFF_FF80, 32'h00FF_80FF);
      rd_chk("brcr2_mask", 32'hFFFF_FF80, 32'h0003_8000);
      wr(32'hFFFF_FF80, 32'h0);
      wr(32'hFFFF_FFC0, 32'h0);

      // Channel 0: CPU ifetch read
      wr(32'hFFFF_FF40, 32'h0600_0100);
      wr(32'hFFFF_FF44, 32'h0);
      wr(32'hFFFF_FF48, 32'h0054_0000);
      rd_chk("bbr0_rd", 32'hFFFF_FF48, 32'h0054_0000);
      mon("ifetch_hit", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      rd_chk("ifetch_cmf", 32'hFFFF_FF80, 32'h0000_0001);
      wr(32'hFFFF_FF80, 32'h0);
      chk("clr_irq_hold", {31'b0, irq2}, 32'h1);
      cycle_r();
      chk("clr_irq_fall", {31'b0, irq2}, 32'h0);
      mon("dma_miss", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      rd_chk("dma_cmf", 32'hFFFF_FF80, 32'h0);

      // Channel 0: masked address, data write with size condition
      wr(32'hFFFF_FF44, 32'h0000_00FF);
      wr(32'hFFFF_FF48, 32'h006B_0000);
      mon("sz_hit", 32'h0600_01AB, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wr(32'hFFFF_FF80, 32'h0);
      cycle_r();
      mon("sz_miss", 32'h0600_01AB, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rd_chk("sz_cmf", 32'hFFFF_FF80, 32'h0);

      // Channel 1 with data compare
      wr(32'hFFFF_FF48, 32'h0);
      wr(32'hFFFF_FF60, 32'h0600_0200);
      wr(32'hFFFF_FF64, 32'h0);
      wr(32'hFFFF_FF68, 32'h0068_0000);
      wr(32'hFFFF_FF70, 32'h1234_5678);
      wr(32'hFFFF_FF74, 32'h0000_FFFF);
      wr(32'hFFFF_FF80, 32'h0002_0000);
      mon("data_hit", 32'h0600_0200, 32'h1234_ABCD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      rd_chk("data_cmf", 32'hFFFF_FF80, 32'h0002_0002);
      wr(32'hFFFF_FF80, 32'h0002_0000);
      cycle_r();
      mon("data_miss", 32'h0600_0200, 32'h1235_ABCD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Sequential mode: ch1 before ch0 is ignored, ch0 arms, ch1 then breaks
      wr(32'hFFFF_FF44, 32'h0);
      wr(32'hFFFF_FF48, 32'h0054_0000);
      wr(32'hFFFF_FF80, 32'h0002_8000);
      mon("seq_ch1_first", 32'h0600_0200, 32'h1234_ABCD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rd_chk("seq_cmf_none", 32'hFFFF_FF80, 32'h0002_8000);
      mon("seq_ch0", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rd_chk("seq_cmf_01", 32'hFFFF_FF80, 32'h0002_8001);
      mon("seq_ch1", 32'h0600_0200, 32'h1234_ABCD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      rd_chk("seq_cmf_11", 32'hFFFF_FF80, 32'h0002_8003);
      wr(32'hFFFF_FF80, 32'h0002_8000);
      chk("seq_clr_hold", {31'b0, irq2}, 32'h1);
      cycle_r();
      chk("seq_clr_fall", {31'b0, irq2}, 32'h0);

      // Sequential mode: simultaneous hits only arm
      wr(32'hFFFF_FF80, 32'h0000_8000);
      wr(32'hFFFF_FF60, 32'h0600_0100);
      wr(32'hFFFF_FF68, 32'h0054_0000);
      mon("seq_both", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rd_chk("seq_both_cmf", 32'hFFFF_FF80, 32'h0000_8001);
      mon("seq_both_armed", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      rd_chk("seq_armed_cmf", 32'hFFFF_FF80, 32'h0000_8003);
      wr(32'hFFFF_FF80, 32'h0000_8000);
      cycle_r();
      chk("seq_both_clr", {31'b0, irq2}, 32'h0);

      // Hardware set of CMF[0] coincident with a software clear
      wr(32'hFFFF_FF68, 32'h0);
      mon_a = 32'h0600_0100; mon_if = 1'b1; mon_we = 1'b0; mon_dma = 1'b0; mon_valid = 1'b1;
      cycle_r();
      mon_valid = 1'b0;
      wr(32'hFFFF_FF80, 32'h0000_8000);
      cycle_r();
      chk("set_wins_irq", {31'b0, irq2}, 32'h0);
      rd_chk("set_wins_cmf", 32'hFFFF_FF80, 32'h0000_8001);

      // Clearing CMF[0] while armed must disarm: a double hit then only re-arms
      wr(32'hFFFF_FF80, 32'h0000_8000);
      wr(32'hFFFF_FF68, 32'h0054_0000);
      mon("disarm", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rd_chk("disarm_cmf", 32'hFFFF_FF80, 32'h0000_8001);

      // Soft reset with IRQ high
      wr(32'hFFFF_FF80, 32'h0);
      mon("pre_res", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      res_n = 1'b0;
      cycle_r();
      res_n = 1'b1;
      chk("res_irq", {31'b0, irq2}, 32'h0);
      rd_chk("res_bar0", 32'hFFFF_FF40, 32'h0);
      rd_chk("res_bbr0", 32'hFFFF_FF48, 32'h0);
      rd_chk("res_bar1", 32'hFFFF_FF60, 32'h0);
      rd_chk("res_brcr", 32'hFFFF_FF80, 32'h0);
      rd_chk("res_unmapped", 32'hFFFF_FF5C, 32'h0);
      mon("res_no_match", 32'h0600_0100, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      chk("sb_empty", sb.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
